// File: rtl/logit_reader.sv
// Fetches NUM_CLASSES signed logits from the fmap bank, tracks their argmax and, when built with
// LOGIT_READER_STREAM_EN, replays the raw logits over a valid/ready byte stream.
module logit_reader #(
   parameter int unsigned NUM_CLASSES = 10,
   parameter logic [14:0] BASE_ADDR   = 15'h0000,
   parameter int unsigned RD_LATENCY  = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        init,
   output logic        done,
   output logic [14:0] fbank_raddr,
   output logic        fbank_ren,
   input  logic [7:0]  fdata_r,
   output logic [3:0]  label,
   output logic        label_valid,
   output logic [7:0]  out_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        out_last
);

   localparam int unsigned CntW    = (RD_LATENCY < 2) ? 1 : $clog2(RD_LATENCY + 1);
   localparam logic [CntW-1:0] LastCnt = CntW'(RD_LATENCY);
   localparam logic [3:0]      LastIdx = 4'(NUM_CLASSES - 1);

`ifdef LOGIT_READER_STREAM_EN
   typedef enum logic [1:0] {StIdle, StFetch, StSend, StDone} state_e;
`else
   typedef enum logic [1:0] {StIdle, StFetch, StDone} state_e;
`endif

   state_e                        state_q, state_d;
   logic [3:0]                    idx_q, idx_d;
   logic [CntW-1:0]               cnt_q, cnt_d;
   logic signed [7:0]             max_q, max_d;
   logic [3:0]                    label_q, label_d;
   logic                          label_valid_q, label_valid_d;
   logic [14:0]                   raddr_q, raddr_d;
   logic                          ren_q, ren_d;
   logic                          done_q, done_d;
   logic [NUM_CLASSES-1:0][7:0]   buf_q, buf_d;
`ifdef LOGIT_READER_STREAM_EN
   logic                          out_valid_q, out_valid_d;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= StIdle;
         idx_q         <= '0;
         cnt_q         <= '0;
         max_q         <= -8'sd128;
         label_q       <= '0;
         label_valid_q <= 1'b0;
         raddr_q       <= '0;
         ren_q         <= 1'b0;
         done_q        <= 1'b0;
         buf_q         <= '0;
`ifdef LOGIT_READER_STREAM_EN
         out_valid_q   <= 1'b0;
`endif
      end else begin
         state_q       <= state_d;
         idx_q         <= idx_d;
         cnt_q         <= cnt_d;
         max_q         <= max_d;
         label_q       <= label_d;
         label_valid_q <= label_valid_d;
         raddr_q       <= raddr_d;
         ren_q         <= ren_d;
         done_q        <= done_d;
         buf_q         <= buf_d;
`ifdef LOGIT_READER_STREAM_EN
         out_valid_q   <= out_valid_d;
`endif
      end
   end

   always_comb begin
      state_d       = state_q;
      idx_d         = idx_q;
      cnt_d         = cnt_q;
      max_d         = max_q;
      label_d       = label_q;
      label_valid_d = label_valid_q;
      raddr_d       = raddr_q;
      ren_d         = 1'b0;
      done_d        = 1'b0;
      buf_d         = buf_q;
`ifdef LOGIT_READER_STREAM_EN
      out_valid_d   = out_valid_q;
`endif

      unique case (state_q)
         StIdle: begin
            if (init) begin
               state_d       = StFetch;
               idx_d         = '0;
               cnt_d         = '0;
               max_d         = -8'sd128;
               label_d       = '0;
               label_valid_d = 1'b0;
               raddr_d       = BASE_ADDR;
               ren_d         = 1'b1;
            end
         end

         StFetch: begin
            // cnt 0 is the request cycle; data is on fdata_r RD_LATENCY cycles later
            if (cnt_q == LastCnt) begin
               buf_d[idx_q] = fdata_r;
               if ($signed(fdata_r) > max_q) begin
                  max_d   = $signed(fdata_r);
                  label_d = idx_q;
               end
               if (idx_q == LastIdx) begin
                  label_valid_d = 1'b1;
`ifdef LOGIT_READER_STREAM_EN
                  state_d       = StSend;
                  idx_d         = '0;
                  out_valid_d   = 1'b1;
`else
                  state_d       = StDone;
`endif
               end else begin
                  idx_d   = idx_q + 4'd1;
                  cnt_d   = '0;
                  raddr_d = BASE_ADDR + 15'(idx_q) + 15'd1;
                  ren_d   = 1'b1;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

`ifdef LOGIT_READER_STREAM_EN
         StSend: begin
            if (out_valid_q && out_ready) begin
               if (idx_q == LastIdx) begin
                  out_valid_d = 1'b0;
                  state_d     = StDone;
               end else begin
                  idx_d = idx_q + 4'd1;
               end
            end
         end
`endif

         StDone: begin
            done_d  = 1'b1;
            state_d = StIdle;
         end

         default: state_d = StIdle;
      endcase
   end

   assign done        = done_q;
   assign fbank_raddr = raddr_q;
   assign fbank_ren   = ren_q;
   assign label       = label_q;
   assign label_valid = label_valid_q;

`ifdef LOGIT_READER_STREAM_EN
   // Data and last come straight from the held index, so they cannot move while stalled
   assign out_valid = out_valid_q;
   assign out_data  = out_valid_q ? buf_q[idx_q] : 8'h00;
   assign out_last  = out_valid_q && (idx_q == LastIdx);
`else
   logic unused_stream;
   assign unused_stream = out_ready ^ (^buf_q);
   assign out_valid     = 1'b0;
   assign out_data      = 8'h00;
   assign out_last      = 1'b0;
`endif

endmodule

// File: tb/tb_logit_reader.sv
// Directed bench for logit_reader: table of logit vectors plus hand-written corner sequences.
// Stream checks are compiled in when LOGIT_READER_STREAM_EN is defined.
module tb_logit_reader;

   localparam int unsigned N = 10;
`ifdef LOGIT_READER_STREAM_EN
   localparam int ExpLat = 42;
`else
   localparam int ExpLat = 32;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        init;
   logic        done;
   logic [14:0] fbank_raddr;
   logic        fbank_ren;
   logic [7:0]  fdata_r;
   logic [3:0]  label;
   logic        label_valid;
   logic [7:0]  out_data;
   logic        out_valid;
   logic        out_ready;
   logic        out_last;

   logit_reader dut (
      .clk         (clk),
      .rst         (rst),
      .init        (init),
      .done        (done),
      .fbank_raddr (fbank_raddr),
      .fbank_ren   (fbank_ren),
      .fdata_r     (fdata_r),
      .label       (label),
      .label_valid (label_valid),
      .out_data    (out_data),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_last    (out_last)
   );

   always #5 clk = ~clk;

   // Two-cycle fmap bank; filler byte outside the valid slot exposes capture-timing errors
   logic [7:0] mem [16];
   logic [7:0] s1 = 8'h55;
   logic [7:0] s2 = 8'h55;
   always @(posedge clk) begin
      s1 <= fbank_ren ? mem[fbank_raddr[3:0]] : 8'h55;
      s2 <= s1;
   end
   assign fdata_r = s2;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [14:0] rd_addr [$];
   logic [7:0]  st_data [$];
   logic        st_last [$];
   int          done_cnt;
   int          done_cyc;
   int          ov_seen;
   always @(negedge clk) begin
      if (fbank_ren) rd_addr.push_back(fbank_raddr);
      if (out_valid && out_ready) begin
         st_data.push_back(out_data);
         st_last.push_back(out_last);
      end
      if (out_valid) ov_seen = ov_seen + 1;
      if (done) begin
         done_cnt = done_cnt + 1;
         done_cyc = cyc;
      end
   end

   typedef struct packed {
      logic [9:0][7:0] lg;
      logic [3:0]      label;
   } vec_t;

   vec_t vecs [5];
   int   raw [5][10] = '{
      '{5, -3, 20, 7, 20, 0, -128, 1, 2, 3},
      '{-128, -128, -128, -128, -128, -128, -128, -128, -128, -128},
      '{127, 127, 127, 127, 127, 127, 127, 127, 127, 127},
      '{-1, -1, -1, -1, -1, -1, -1, -1, -1, 127},
      '{-5, -4, -3, -2, -1, -6, -7, -8, -9, -10}
   };
   int   exp_label [5] = '{2, 0, 0, 9, 4};

   int pass_cnt = 0;
   int total_cnt = 0;
   int init_cyc;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
   endtask

   task automatic check_zero(input string p);
      check({p, "_done"}, 32'(done), 0);
      check({p, "_raddr"}, 32'(fbank_raddr), 0);
      check({p, "_ren"}, 32'(fbank_ren), 0);
      check({p, "_label"}, 32'(label), 0);
      check({p, "_label_valid"}, 32'(label_valid), 0);
      check({p, "_out_data"}, 32'(out_data), 0);
      check({p, "_out_valid"}, 32'(out_valid), 0);
      check({p, "_out_last"}, 32'(out_last), 0);
   endtask

   task automatic clear_logs(input int v);
      rd_addr.delete();
      st_data.delete();
      st_last.delete();
      done_cnt = 0;
      ov_seen  = 0;
      for (int k = 0; k < 16; k++) mem[k] = (k < N) ? vecs[v].lg[k] : 8'hee;
   endtask

   task automatic pulse_init();
      @(posedge clk);
      #1;
      init     = 1'b1;
      init_cyc = cyc;
      @(posedge clk);
      #1;
      init = 1'b0;
   endtask

   task automatic stall_seq(input int v);
      int n = 0;
      int bad = 0;
      while (st_data.size() < 3 && n < 200) begin
         @(posedge clk);
         #1;
         n++;
      end
      out_ready = 1'b0;
      repeat (5) begin
         @(negedge clk);
         if (out_valid !== 1'b1 || out_data !== vecs[v].lg[3]) bad++;
      end
      check("stall_hold", bad, 0);
      @(posedge clk);
      #1;
      out_ready = 1'b1;
   endtask

   task automatic run_job(input int v, input int reinit_at, input bit stall, input int exp_lat);
      int bad;
      clear_logs(v);
      pulse_init();
      check("label_valid_cleared", 32'(label_valid), 0);
      fork
         begin
            int n = 0;
            while (done_cnt == 0 && n < 300) begin
               @(posedge clk);
               n++;
            end
         end
         begin
            if (reinit_at > 0) begin
               repeat (reinit_at) @(posedge clk);
               #1;
               init = 1'b1;
               @(posedge clk);
               #1;
               init = 1'b0;
            end
         end
         begin
            if (stall) stall_seq(v);
         end
      join
      repeat (3) @(posedge clk);
      #1;
      check("done_pulses", done_cnt, 1);
      check("done_latency", done_cyc - init_cyc, exp_lat);
      check("label", 32'(label), 32'(vecs[v].label));
      check("label_valid", 32'(label_valid), 1);
      check("read_count", rd_addr.size(), N);
      bad = 0;
      foreach (rd_addr[k]) if (rd_addr[k] !== 15'(k)) bad++;
      check("read_addr", bad, 0);
`ifdef LOGIT_READER_STREAM_EN
      check("stream_len", st_data.size(), N);
      bad = 0;
      foreach (st_data[k]) begin
         if (k >= N) bad++;
         else if (st_data[k] !== vecs[v].lg[k] || st_last[k] !== (k == N - 1)) bad++;
      end
      check("stream_bytes", bad, 0);
`else
      check("no_out_valid", ov_seen, 0);
`endif
   endtask

   initial begin
      for (int v = 0; v < 5; v++) begin
         for (int k = 0; k < N; k++) vecs[v].lg[k] = 8'(raw[v][k]);
         vecs[v].label = 4'(exp_label[v]);
      end
      rst       = 1'b0;
      init      = 1'b0;
      out_ready = 1'b1;
      #2 rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_zero("reset");
      @(posedge clk);
      #1;
      rst = 1'b0;

      for (int v = 0; v < 5; v++) run_job(v, 0, 1'b0, ExpLat);

      // Second init mid-FETCH must be ignored
      run_job(0, 8, 1'b0, ExpLat);

`ifdef LOGIT_READER_STREAM_EN
      run_job(4, 0, 1'b1, ExpLat + 5);
`endif

      // Reset mid-job, then a clean job afterwards
      begin
         int n = 0;
         clear_logs(3);
         pulse_init();
`ifdef LOGIT_READER_STREAM_EN
         while (st_data.size() < 4 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
         end
         check("reach_byte4", st_data.size(), 4);
`else
         repeat (15) @(posedge clk);
         #1;
`endif
         rst = 1'b1;
         @(negedge clk);
         check_zero("mid_rst");
         @(posedge clk);
         #1;
         rst = 1'b0;
         run_job(3, 0, 1'b0, ExpLat);
      end

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
